ps2_host_tx: RTL

//  PS/2 host-to-device transmitter: sends one command byte (e.g. 0xF4 enable reporting, 0xFF reset) to the mouse.

---
 rtl/ps2_host_tx_if.sv | 38 +++
 rtl/ps2_host_tx.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_host_tx_if
//  Description : Command handshake, status flags and PS/2 line sense/drive
//                signals of the PS/2 host transmitter.
//  Revision    : 1.0  initial release
// ============================================================================
interface ps2_host_tx_if;
    // command handshake
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    // status
    logic       busy;
    logic       tx_done;
    logic       tx_ack_ok;
    logic       tx_error;
    // shared open-drain PS/2 lines
    logic       ps2_clk_i;
    logic       ps2_data_i;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;

    // user side: issues commands, senses the physical lines
    modport master (
        output tx_valid, tx_data, ps2_clk_i, ps2_data_i,
        input  tx_ready, busy, tx_done, tx_ack_ok, tx_error,
        input  ps2_clk_oe, ps2_data_oe
    );

    // transmitter side
    modport slave (
        input  tx_valid, tx_data, ps2_clk_i, ps2_data_i,
        output tx_ready, busy, tx_done, tx_ack_ok, tx_error,
        output ps2_clk_oe, ps2_data_oe
    );
endinterface
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_host_tx
//  Description : PS/2 host-to-device command transmitter. Inhibits the bus,
//                issues request-to-send, shifts out 8 data bits LSB first,
//                odd parity and stop on device clock falls, then samples the
//                device ACK. Aborts on a missing device clock.
//  Revision    : 1.0  initial release
// ============================================================================
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  wire logic    clk,
    input  wire logic    rstn,
    ps2_host_tx_if.slave bus
);

    localparam int CNT_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INHIBIT   = 3'd1,
        S_RTS       = 3'd2,
        S_DATA      = 3'd3,
        S_PARITY    = 3'd4,
        S_STOP      = 3'd5,
        S_ACK       = 3'd6,
        S_WAIT_IDLE = 3'd7
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       byte_q, byte_d;
    logic             par_q, par_d;
    logic [2:0]       bit_q, bit_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             clk_oe_q, clk_oe_d;
    logic             data_oe_q, data_oe_d;
    logic             ack_ok_q, ack_ok_d;
    logic             done_q, done_d;
    logic             error_q, error_d;

    logic [1:0]       clk_sync_q;
    logic [1:0]       data_sync_q;
    logic             clk_prev_q;

    logic             clk_s;
    logic             data_s;
    logic             clk_fall;
    logic             ready;
    logic             in_xfer;

    // Synchronise the asynchronous line senses; reset to the idle-high level
    // so no spurious fall appears after reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], bus.ps2_clk_i};
            data_sync_q <= {data_sync_q[0], bus.ps2_data_i};
            clk_prev_q  <= clk_sync_q[1];
        end
    end

    assign clk_s    = clk_sync_q[1];
    assign data_s   = data_sync_q[1];
    assign clk_fall = clk_prev_q & ~clk_s;

    // Ready is withheld on the pulse cycle so a held request starts one
    // cycle after tx_done/tx_error.
    assign ready   = (state_q == S_IDLE) && !done_q && !error_q;
    assign in_xfer = (state_q == S_DATA)   || (state_q == S_PARITY) ||
                     (state_q == S_STOP)   || (state_q == S_ACK)    ||
                     (state_q == S_WAIT_IDLE);

    // State and datapath registers; reset releases both lines immediately.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            byte_q    <= 8'h00;
            par_q     <= 1'b0;
            bit_q     <= 3'd0;
            cnt_q     <= '0;
            timer_q   <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            ack_ok_q  <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            byte_q    <= byte_d;
            par_q     <= par_d;
            bit_q     <= bit_d;
            cnt_q     <= cnt_d;
            timer_q   <= timer_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            ack_ok_q  <= ack_ok_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    // Next-state, line-drive and status decode, with the timeout watchdog
    // overriding the protocol steps once the device owns the clock.
    always_comb begin
        state_d   = state_q;
        byte_d    = byte_q;
        par_d     = par_q;
        bit_d     = bit_q;
        cnt_d     = cnt_q;
        timer_d   = timer_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        ack_ok_d  = ack_ok_q;
        done_d    = 1'b0;
        error_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.tx_valid && ready) begin
                    byte_d    = bus.tx_data;
                    par_d     = ~^bus.tx_data;
                    ack_ok_d  = 1'b0;
                    cnt_d     = '0;
                    clk_oe_d  = 1'b1;
                    data_oe_d = 1'b0;
                    state_d   = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                clk_oe_d  = 1'b1;
                data_oe_d = 1'b0;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == INH_LAST) begin
                    data_oe_d = 1'b1;       // start bit
                    state_d   = S_RTS;
                end
            end
            S_RTS: begin
                clk_oe_d  = 1'b0;           // hand the clock to the device
                data_oe_d = 1'b1;
                bit_d     = 3'd0;
                timer_d   = '0;
                state_d   = S_DATA;
            end
            S_DATA: begin
                if (clk_fall) begin
                    data_oe_d = ~byte_q[bit_q];
                    if (bit_q == 3'd7) begin
                        state_d = S_PARITY;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (clk_fall) begin
                    data_oe_d = ~par_q;
                    state_d   = S_STOP;
                end
            end
            S_STOP: begin
                if (clk_fall) begin
                    data_oe_d = 1'b0;       // stop bit: line released high
                    state_d   = S_ACK;
                end
            end
            S_ACK: begin
                if (clk_fall) begin
                    ack_ok_d = ~data_s;
                    state_d  = S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                if (clk_s && data_s) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (in_xfer && !done_d) begin
            if (clk_fall) begin
                timer_d = '0;
            end else if (timer_q == TMR_LAST) begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                ack_ok_d  = 1'b0;
                error_d   = 1'b1;
                timer_d   = '0;
                state_d   = S_IDLE;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end
    end

    assign bus.tx_ready    = ready;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.tx_done     = done_q;
    assign bus.tx_ack_ok   = ack_ok_q;
    assign bus.tx_error    = error_q;
    assign bus.ps2_clk_oe  = clk_oe_q;
    assign bus.ps2_data_oe = data_oe_q;

endmodule
`default_nettype wire
